// File: rtl/fp_apb_master_pkg.sv
// Shared definitions for the FP co-processor APB link: opcodes, FSM
// encoding and the instruction-to-paddr packing.
package fp_apb_pkg;

  localparam logic [3:0] OP_STORE = 4'ha;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_READ  = 4'hb;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RETRY  = 3'd3,
    ST_RESP   = 3'd4
  } apb_state_e;

  // Map one co-processor instruction onto the slave's paddr layout.
  function automatic logic [31:0] pack_paddr(
    input logic [3:0] op,
    input logic [3:0] dest,
    input logic [3:0] src1,
    input logic [3:0] src2,
    input logic [7:0] sram_addr
  );
    logic [31:0] addr;
    case (op)
      OP_STORE: addr = {op, sram_addr, 20'h0_0000};
      OP_LOAD:  addr = {op, sram_addr, dest, 16'h0000};
      OP_READ:  addr = {28'h000_0000, src1};
      default:  addr = {op, dest, src1, src2, 16'h0000};
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/fp_apb_master_if.sv
// Command, APB and response signals between host, initiator and co-processor.
interface fp_apb_master_if;
  import fp_apb_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [3:0]  cmd_dest;
  logic [3:0]  cmd_src1;
  logic [3:0]  cmd_src2;
  logic [7:0]  cmd_sram_addr;
  logic [31:0] cmd_wdata;

  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_dest, cmd_src1, cmd_src2, cmd_sram_addr, cmd_wdata,
    output cmd_ready,
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_dest, cmd_src1, cmd_src2, cmd_sram_addr, cmd_wdata,
    input  cmd_ready,
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready
  );

endinterface

// File: rtl/fp_apb_master.sv
// APB initiator for the FP co-processor: one command in, one APB transfer
// (with retry on pslverr and wait-state timeout), one response out.
module fp_apb_master
  import fp_apb_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic               apb_clk,
  input logic               preset,
  fp_apb_master_if.master   bus
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  apb_state_e      state;
  logic [RW-1:0]   retry_cnt;
  logic [TW-1:0]   tmo_cnt;

  // Handshake and APB phase strobes decode straight from the state so that
  // reset clears them asynchronously along with the state register.
  always_comb begin
    bus.cmd_ready = (state == ST_IDLE);
    bus.rsp_valid = (state == ST_RESP);
    bus.psel      = (state == ST_SETUP) || (state == ST_ACCESS);
    bus.penable   = (state == ST_ACCESS);
  end

  // Transfer sequencing, registered command fields and response capture.
  always_ff @(posedge apb_clk or posedge preset) begin
    if (preset) begin
      state           <= ST_IDLE;
      retry_cnt       <= '0;
      tmo_cnt         <= '0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.pwrite      <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            bus.paddr       <= pack_paddr(bus.cmd_opcode, bus.cmd_dest, bus.cmd_src1,
                                          bus.cmd_src2, bus.cmd_sram_addr);
            bus.pwdata      <= (bus.cmd_opcode == OP_STORE) ? bus.cmd_wdata : '0;
            bus.pwrite      <= (bus.cmd_opcode != OP_READ);
            retry_cnt       <= '0;
            tmo_cnt         <= '0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            state           <= ST_SETUP;
          end
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          if (bus.pready) begin
            if (!bus.pslverr) begin
              // Only reads carry pwrite=0, so pwrite doubles as the read flag.
              if (!bus.pwrite) bus.rsp_rdata <= bus.prdata;
              state <= ST_RESP;
            end else if (retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_RETRY;
            end else begin
              bus.rsp_err <= 1'b1;
              state       <= ST_RESP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
              bus.rsp_timeout <= 1'b1;
              state           <= ST_RESP;
            end
          end
        end
        ST_RETRY: state <= ST_SETUP;
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_apb_master.sv
// Bench for fp_apb_master: scripted APB slave, scoreboard of expected
// responses pushed at command issue and popped at the response handshake.
module tb_fp_apb_master;

  localparam int MAX_RETRY = 2;
  localparam int TIMEOUT   = 64;

  logic tb_apb_clk = 1'b0;
  logic preset     = 1'b0;

  always #5 tb_apb_clk = ~tb_apb_clk;

  fp_apb_master_if bus();

  fp_apb_master #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .apb_clk (tb_apb_clk),
    .preset  (preset),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] rdata;
    logic        pwrite;
    logic        err;
    logic        tmo;
    int          lat;
    int          setups;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Independent address model built field by field.
  function automatic logic [31:0] model_paddr(input logic [3:0] op, input logic [3:0] dest,
                                              input logic [3:0] s1, input logic [3:0] s2,
                                              input logic [7:0] sram);
    logic [31:0] a;
    a = '0;
    if (op == 4'hb) begin
      a[3:0] = s1;
    end else begin
      a[31:28] = op;
      if (op == 4'ha) begin
        a[27:20] = sram;
      end else if (op == 4'h2) begin
        a[27:20] = sram;
        a[19:16] = dest;
      end else begin
        a[27:24] = dest;
        a[23:20] = s1;
        a[19:16] = s2;
      end
    end
    return a;
  endfunction

  task automatic run_txn(input string name, input logic [3:0] op, input logic [3:0] dest,
                         input logic [3:0] s1, input logic [3:0] s2, input logic [7:0] sram,
                         input logic [31:0] wd, input int waits, input int errs,
                         input bit stuck, input logic [31:0] prd);
    exp_t e;
    exp_t got;
    int   attempts, cyc, setups, idles, attempt, acc;
    bit   done;
    logic [31:0] rdata_hold;

    attempts = stuck ? 1 : (((errs > MAX_RETRY) ? MAX_RETRY : errs) + 1);
    e.paddr  = model_paddr(op, dest, s1, s2, sram);
    e.pwdata = (op == 4'ha) ? wd : 32'h0;
    e.pwrite = (op != 4'hb);
    e.err    = !stuck && (errs > MAX_RETRY);
    e.tmo    = stuck;
    e.rdata  = (op == 4'hb && !e.err && !stuck) ? prd : 32'h0;
    e.lat    = stuck ? (TIMEOUT + 2) : (attempts * (waits + 2) + (attempts - 1) + 1);
    e.setups = attempts;
    sb.push_back(e);

    @(negedge tb_apb_clk);
    chk({name, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_opcode    = op;
    bus.cmd_dest      = dest;
    bus.cmd_src1      = s1;
    bus.cmd_src2      = s2;
    bus.cmd_sram_addr = sram;
    bus.cmd_wdata     = wd;
    bus.cmd_valid     = 1'b1;
    @(negedge tb_apb_clk);
    bus.cmd_valid = 1'b0;

    cyc = 1; setups = 0; idles = 0; attempt = -1; acc = 0; done = 1'b0;
    while (!done && cyc <= TIMEOUT + 20) begin
      if (bus.rsp_valid) begin
        done = 1'b1;
      end else begin
        if (bus.psel && !bus.penable) begin
          setups++;
          attempt++;
          acc = 0;
          chk({name, ".paddr"},  bus.paddr,  e.paddr);
          chk({name, ".pwdata"}, bus.pwdata, e.pwdata);
          chk({name, ".pwrite"}, 32'(bus.pwrite), 32'(e.pwrite));
          bus.pready  = 1'b0;
          bus.pslverr = 1'($urandom_range(0, 1));
          bus.prdata  = $urandom;
        end else if (bus.psel && bus.penable) begin
          if (stuck || acc < waits) begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'($urandom_range(0, 1));
            bus.prdata  = $urandom;
          end else begin
            bus.pready  = 1'b1;
            bus.pslverr = (attempt < errs);
            bus.prdata  = prd;
          end
          acc++;
        end else begin
          idles++;
          bus.pready  = 1'b0;
          bus.pslverr = 1'b0;
        end
        @(negedge tb_apb_clk);
        cyc++;
      end
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;

    got = sb.pop_front();
    if (!done) begin
      chk({name, ".rsp_wait"}, 32'd0, 32'd1);
      preset = 1'b1;
      @(negedge tb_apb_clk);
      preset = 1'b0;
      return;
    end

    chk({name, ".latency"},   32'(cyc),             32'(got.lat));
    chk({name, ".setups"},    32'(setups),          32'(got.setups));
    chk({name, ".idles"},     32'(idles),           32'(got.setups - 1));
    chk({name, ".rsp_rdata"}, bus.rsp_rdata,        got.rdata);
    chk({name, ".rsp_err"},   32'(bus.rsp_err),     32'(got.err));
    chk({name, ".rsp_tmo"},   32'(bus.rsp_timeout), 32'(got.tmo));
    chk({name, ".psel_resp"}, 32'({bus.psel, bus.penable}), 32'd0);

    // Hold the response off for a cycle while a stray command is offered.
    rdata_hold    = bus.rsp_rdata;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = 4'h5;
    @(negedge tb_apb_clk);
    chk({name, ".rsp_hold"},   32'(bus.rsp_valid), 32'd1);
    chk({name, ".busy"},       32'(bus.cmd_ready), 32'd0);
    chk({name, ".rdata_hold"}, bus.rsp_rdata,      rdata_hold);
    chk({name, ".paddr_hold"}, bus.paddr,          got.paddr);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge tb_apb_clk);
    bus.rsp_ready = 1'b0;
    chk({name, ".rsp_done"}, 32'(bus.rsp_valid), 32'd0);
    chk({name, ".idle"},     32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_dest = '0; bus.cmd_src1 = '0;
    bus.cmd_src2 = '0; bus.cmd_sram_addr = '0; bus.cmd_wdata = '0;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0; bus.rsp_ready = 1'b0;

    #3 preset = 1'b1;
    #1;
    chk("rst.paddr",  bus.paddr,  32'h0);
    chk("rst.pwdata", bus.pwdata, 32'h0);
    chk("rst.strobes", 32'({bus.pwrite, bus.psel, bus.penable, bus.rsp_valid}), 32'h0);
    chk("rst.rsp",    32'({bus.rsp_err, bus.rsp_timeout}), 32'h0);
    chk("rst.rdata",  bus.rsp_rdata, 32'h0);
    chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (2) @(negedge tb_apb_clk);
    preset = 1'b0;

    run_txn("store",    4'ha, 4'h0, 4'h0, 4'h0, 8'h01, 32'h17A55DE7, 0, 0, 1'b0, 32'h0);
    run_txn("load",     4'h2, 4'h1, 4'h0, 4'h0, 8'h01, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0);
    run_txn("add",      4'h3, 4'h2, 4'h0, 4'h1, 8'h00, 32'h0,        0, 0, 1'b0, 32'h0);
    run_txn("read",     4'hb, 4'h0, 4'h2, 4'h0, 8'h00, 32'h0,        3, 0, 1'b0, 32'h40490FDB);
    run_txn("err_all",  4'h4, 4'h3, 4'h1, 4'h2, 8'h00, 32'h0,        0, 5, 1'b0, 32'h0);
    run_txn("retry_ok", 4'hb, 4'h0, 4'h7, 4'h0, 8'h00, 32'h0,        1, 1, 1'b0, 32'h3F800000);
    run_txn("timeout",  4'ha, 4'h0, 4'h0, 4'h0, 8'hFF, 32'h12345678, 0, 0, 1'b1, 32'h0);

    // Reset in the middle of an access: strobes drop without waiting for a clock.
    @(negedge tb_apb_clk);
    bus.cmd_opcode = 4'ha; bus.cmd_sram_addr = 8'h42; bus.cmd_wdata = 32'hCAFEF00D;
    bus.cmd_valid = 1'b1;
    @(negedge tb_apb_clk);
    bus.cmd_valid = 1'b0;
    @(negedge tb_apb_clk);
    chk("mid.in_access", 32'({bus.psel, bus.penable}), 32'h3);
    #2 preset = 1'b1;
    #1;
    chk("mid.strobes", 32'({bus.psel, bus.penable, bus.rsp_valid}), 32'h0);
    chk("mid.paddr",   bus.paddr, 32'h0);
    @(negedge tb_apb_clk);
    preset = 1'b0;
    @(negedge tb_apb_clk);
    chk("mid.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid.no_rsp",    32'(bus.rsp_valid), 32'd0);

    run_txn("after_rst", 4'ha, 4'h0, 4'h0, 4'h0, 8'h10, 32'hA5A5A5A5, 2, 0, 1'b0, 32'h0);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
